exe_mem_stage_reg: RTL and testbench
====================================

// Module: exe_mem_stage_reg
// PURPOSE
// - EXE->MEM pipeline register plus the NZCV status register. Sits directly downstream of the ALU.
// - Captures the ALU result and flags each cycle and forwards control and data to the MEM stage.
// - Commits flags to the status register for S-suffixed instructions.
// - Supplies the registered C flag back to the ALU carry-in and NZCV to the ID-stage condition check.
// PARAMETERS
// DATA_W     32  datapath width (ALU result, store data)
// REG_ADDR_W 4   destination register index width
// PORTS
// clk          in   1       rising-edge clock
// rst_n        in   1       asynchronous active-low reset
// freeze       in   1       MEM stall: hold all registered state
// flush        in   1       kill instruction entering this stage (branch taken)
// exe_valid    in   1       EXE stage holds a real instruction
// exe_s        in   1       instruction updates status (S bit)
// exe_wb_en    in   1       writeback enable
// exe_mem_r_en in   1       load
// exe_mem_w_en in   1       store
// exe_dest     in   REG_ADDR_W  destination register
// exe_alu_res  in   DATA_W  ALU result (address for load/store)
// exe_val_rm   in   DATA_W  store data
// alu_n, alu_z, alu_c, alu_v  in 1 each  ALU flags, same cycle as exe_alu_res
// mem_valid    out  1       registered valid
// mem_wb_en, mem_mem_r_en, mem_mem_w_en  out 1 each  registered controls
// mem_dest     out  REG_ADDR_W  registered destination
// mem_alu_res  out  DATA_W  registered result
// mem_val_rm   out  DATA_W  registered store data
// status       out  4       NZCV, bit3=N .. bit0=V
// c_to_alu     out  1       status[1], wired to ALU C_in
// BEHAVIOUR
// - Reset (rst_n=0, async): all outputs 0, i.e. valid/controls/dest/data/status=0. Takes effect immediately without waiting for a clock edge.
// - Latency: 1 cycle. Inputs sampled at posedge clk appear on mem_* after that edge.
// - Priority at each posedge, highest first:
//   1. freeze=1: hold all state. Status does not update. flush is ignored; upstream keeps flush asserted until freeze drops.
//   2. flush=1: mem_valid, mem_wb_en, mem_mem_r_en, mem_mem_w_en <= 0. Data/dest fields are don't-care; they load the inputs. Status is not updated.
//   3. else: load all fields. mem_valid <= exe_valid.
//   4. With exe_valid=0, the controls load as 0 regardless of their inputs, so bubbles never write.
// - Status write: status <= {alu_n,alu_z,alu_c,alu_v} only when exe_valid & exe_s & ~freeze & ~flush. Otherwise it holds.
// - Status is visible at its outputs the cycle after the commit edge.
// - c_to_alu is purely registered: status[1] with no combinational path from alu_c.
//   - An ADC/SBC directly following a flag-setting op sees the committed carry one cycle later.
//   - ID-stage hazard logic stalls one cycle for that case; this block implements no bypass.
// - Flags for MOV/MVN/logic ops arrive from the ALU with C=V=0 and are committed as-is.
// - No combinational input->output paths other than c_to_alu = status[1].
// - Reset mid-operation: all in-flight state is discarded. The first instruction after rst_n rises is captured normally.
// TESTING
// - Reset: rst_n=0 mid-cycle with mem_valid=1, status=4'hF -> all outputs 0 before the next clk edge.
// - Pass-through: exe_valid=1, wb_en=1, dest=4'd5, alu_res=32'h0000_0010 -> next cycle mem_valid=1, mem_dest=5, mem_alu_res=32'h10.
// - Status: exe_s=1, flags N,Z,C,V=0,1,1,0 -> status=4'b0110, c_to_alu=1 next cycle. Same with exe_s=0 -> status unchanged.
// - Freeze: hold freeze=1 for 3 cycles while inputs change and exe_s=1 -> mem_* and status constant; they update on the first edge after freeze=0.
// - Flush: flush=1, exe_valid=1, mem_w_en=1, exe_s=1 -> mem_valid=0, mem_mem_w_en=0, status unchanged. With freeze=1 as well -> state held.
// - Bubble: exe_valid=0, exe_wb_en=1, exe_mem_w_en=1 -> mem_wb_en=0, mem_mem_w_en=0, mem_valid=0.

Source files
------------

// File: rtl/exe_mem_stage_reg_if.sv
// EXE->MEM boundary bundle: EXE-side capture inputs, MEM-side registered
// outputs, and the NZCV status taps fed back to the ALU and ID stage.
interface exe_mem_stage_reg_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 4
);
  // pipeline control
  logic                  freeze;
  logic                  flush;
  // EXE-stage side
  logic                  exe_valid;
  logic                  exe_s;
  logic                  exe_wb_en;
  logic                  exe_mem_r_en;
  logic                  exe_mem_w_en;
  logic [REG_ADDR_W-1:0] exe_dest;
  logic [DATA_W-1:0]     exe_alu_res;
  logic [DATA_W-1:0]     exe_val_rm;
  logic                  alu_n;
  logic                  alu_z;
  logic                  alu_c;
  logic                  alu_v;
  // MEM-stage side
  logic                  mem_valid;
  logic                  mem_wb_en;
  logic                  mem_mem_r_en;
  logic                  mem_mem_w_en;
  logic [REG_ADDR_W-1:0] mem_dest;
  logic [DATA_W-1:0]     mem_alu_res;
  logic [DATA_W-1:0]     mem_val_rm;
  // status feedback
  logic [3:0]            status;
  logic                  c_to_alu;

  // Upstream/environment view: drives EXE signals, observes MEM outputs
  modport master (
    output freeze, flush,
    output exe_valid, exe_s, exe_wb_en, exe_mem_r_en, exe_mem_w_en,
    output exe_dest, exe_alu_res, exe_val_rm,
    output alu_n, alu_z, alu_c, alu_v,
    input  mem_valid, mem_wb_en, mem_mem_r_en, mem_mem_w_en,
    input  mem_dest, mem_alu_res, mem_val_rm,
    input  status, c_to_alu
  );

  // Stage-register view
  modport slave (
    input  freeze, flush,
    input  exe_valid, exe_s, exe_wb_en, exe_mem_r_en, exe_mem_w_en,
    input  exe_dest, exe_alu_res, exe_val_rm,
    input  alu_n, alu_z, alu_c, alu_v,
    output mem_valid, mem_wb_en, mem_mem_r_en, mem_mem_w_en,
    output mem_dest, mem_alu_res, mem_val_rm,
    output status, c_to_alu
  );
endinterface

// File: rtl/exe_mem_stage_reg.sv
// EXE->MEM pipeline register with the NZCV status register.
// freeze holds everything; flush squashes valid/controls and blocks the
// status commit; bubbles (exe_valid=0) never carry live controls.
module exe_mem_stage_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  exe_mem_stage_reg_if.slave    bus
);

  logic                  r_valid;
  logic                  r_wb_en;
  logic                  r_mem_r_en;
  logic                  r_mem_w_en;
  logic [REG_ADDR_W-1:0] r_dest;
  logic [DATA_W-1:0]     r_alu_res;
  logic [DATA_W-1:0]     r_val_rm;
  logic [3:0]            r_status;

  logic                  w_live;
  logic                  w_commit;
  logic [3:0]            w_flags;

  // Live instruction = real and not squashed; only it may carry controls or set flags
  always_comb begin
    w_live   = bus.exe_valid & ~bus.flush;
    w_commit = w_live & bus.exe_s;
    w_flags  = {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
  end

  // Pipeline register: async clear, freeze holds, flush/bubble zero the controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_wb_en    <= 1'b0;
      r_mem_r_en <= 1'b0;
      r_mem_w_en <= 1'b0;
      r_dest     <= '0;
      r_alu_res  <= '0;
      r_val_rm   <= '0;
    end else if (!bus.freeze) begin
      r_valid    <= w_live;
      r_wb_en    <= w_live & bus.exe_wb_en;
      r_mem_r_en <= w_live & bus.exe_mem_r_en;
      r_mem_w_en <= w_live & bus.exe_mem_w_en;
      r_dest     <= bus.exe_dest;
      r_alu_res  <= bus.exe_alu_res;
      r_val_rm   <= bus.exe_val_rm;
    end
  end

  // Status register: commit NZCV only for live S-suffixed instructions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status <= '0;
    end else if (!bus.freeze && w_commit) begin
      r_status <= w_flags;
    end
  end

  // Outputs are straight register taps; carry-in is registered only (no bypass)
  always_comb begin
    bus.mem_valid    = r_valid;
    bus.mem_wb_en    = r_wb_en;
    bus.mem_mem_r_en = r_mem_r_en;
    bus.mem_mem_w_en = r_mem_w_en;
    bus.mem_dest     = r_dest;
    bus.mem_alu_res  = r_alu_res;
    bus.mem_val_rm   = r_val_rm;
    bus.status       = r_status;
    bus.c_to_alu     = r_status[1];
  end

endmodule

// File: tb/tb_exe_mem_stage_reg.sv
// Scoreboard bench for exe_mem_stage_reg: stimulus predicts the post-edge
// state from the stage rules and queues it; a monitor compares after every
// clock edge and every reset assertion.
module tb_exe_mem_stage_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  exe_mem_stage_reg_if #(.DATA_W(DW), .REG_ADDR_W(AW)) bus ();

  exe_mem_stage_reg #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic          valid;
    logic          wb;
    logic          rd;
    logic          wr;
    logic [AW-1:0] dest;
    logic [DW-1:0] res;
    logic [DW-1:0] rm;
    logic [3:0]    st;
  } exp_t;

  exp_t model;
  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic exp_t zero_state();
    exp_t z;
    z.valid = 1'b0; z.wb = 1'b0; z.rd = 1'b0; z.wr = 1'b0;
    z.dest = '0; z.res = '0; z.rm = '0; z.st = '0;
    return z;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, expv);
    end
  endtask

  // Monitor: one queued expectation per clock edge / reset assertion
  initial begin
    exp_t e;
    #1;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow @%0t: got no expectation expected one queued", $time);
      end else begin
        e = exp_q.pop_front();
        chk("mem_valid",    DW'(bus.mem_valid),    DW'(e.valid));
        chk("mem_wb_en",    DW'(bus.mem_wb_en),    DW'(e.wb));
        chk("mem_mem_r_en", DW'(bus.mem_mem_r_en), DW'(e.rd));
        chk("mem_mem_w_en", DW'(bus.mem_mem_w_en), DW'(e.wr));
        chk("mem_dest",     DW'(bus.mem_dest),     DW'(e.dest));
        chk("mem_alu_res",  bus.mem_alu_res,       e.res);
        chk("mem_val_rm",   bus.mem_val_rm,        e.rm);
        chk("status",       DW'(bus.status),       DW'(e.st));
        chk("c_to_alu",     DW'(bus.c_to_alu),     DW'(e.st[1]));
      end
    end
  end

  // Drive one cycle of inputs, predict the state after the coming edge, advance
  task automatic step(input bit fz, input bit fl, input bit v, input bit s,
                      input bit wb, input bit rd, input bit wr,
                      input logic [AW-1:0] dest, input logic [DW-1:0] res,
                      input logic [DW-1:0] rm, input logic [3:0] nzcv);
    bus.freeze = fz;       bus.flush = fl;
    bus.exe_valid = v;     bus.exe_s = s;
    bus.exe_wb_en = wb;    bus.exe_mem_r_en = rd;  bus.exe_mem_w_en = wr;
    bus.exe_dest = dest;   bus.exe_alu_res = res;  bus.exe_val_rm = rm;
    {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} = nzcv;
    if (!fz) begin
      model.dest = dest;
      model.res  = res;
      model.rm   = rm;
      if (fl || !v) begin
        model.valid = 1'b0; model.wb = 1'b0; model.rd = 1'b0; model.wr = 1'b0;
      end else begin
        model.valid = 1'b1; model.wb = wb; model.rd = rd; model.wr = wr;
        if (s) model.st = nzcv;
      end
    end
    exp_q.push_back(model);
    @(posedge clk);
    #2;
  endtask

  task automatic rand_step(input int fz_pct, input int fl_pct);
    step($urandom_range(99) < fz_pct, $urandom_range(99) < fl_pct,
         $urandom_range(99) < 75, $urandom_range(1) == 1,
         $urandom_range(1) == 1, $urandom_range(1) == 1, $urandom_range(1) == 1,
         AW'($urandom), $urandom, $urandom, 4'($urandom_range(15)));
  endtask

  // Reset asserted mid-cycle: outputs must clear before the next edge
  task automatic mid_reset();
    model = zero_state();
    exp_q.push_back(model);   // checked just after rst_n falls
    exp_q.push_back(model);   // checked after the edge that occurs inside reset
    bus.exe_valid = 1'b1; bus.exe_s = 1'b1; bus.exe_wb_en = 1'b1;
    {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} = 4'hF;
    #1 rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    model = zero_state();
    bus.freeze = 1'b0; bus.flush = 1'b0; bus.exe_valid = 1'b0; bus.exe_s = 1'b0;
    bus.exe_wb_en = 1'b0; bus.exe_mem_r_en = 1'b0; bus.exe_mem_w_en = 1'b0;
    bus.exe_dest = '0; bus.exe_alu_res = '0; bus.exe_val_rm = '0;
    {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} = 4'h0;
    exp_q.push_back(model);   // first edge happens while in reset
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // pass-through
    step(0,0,1,0, 1,0,0, 4'd5, 32'h0000_0010, 32'hDEAD_BEEF, 4'h0);
    // status commit, then S=0 must not change it
    step(0,0,1,1, 1,0,0, 4'd1, 32'h1, 32'h2, 4'b0110);
    step(0,0,1,0, 1,0,0, 4'd2, 32'h3, 32'h4, 4'b1001);
    // freeze for 3 cycles with changing inputs and S=1, then release
    step(1,0,1,1, 1,1,0, 4'd7, 32'hAAAA_0001, 32'h11, 4'b1000);
    step(1,1,1,1, 0,0,1, 4'd8, 32'hAAAA_0002, 32'h22, 4'b0001);
    step(1,0,0,1, 1,1,1, 4'd9, 32'hAAAA_0003, 32'h33, 4'b1111);
    step(0,0,1,1, 1,0,0, 4'd10, 32'hBBBB_0000, 32'h44, 4'b1010);
    // flush of a store with S=1, then flush together with freeze
    step(0,1,1,1, 0,0,1, 4'd3, 32'h5555, 32'h6666, 4'b0101);
    step(0,0,1,0, 0,1,0, 4'd4, 32'h7777, 32'h8888, 4'b0000);
    step(1,1,1,1, 0,0,1, 4'd6, 32'h9999, 32'hAAAA, 4'b0011);
    // bubble with controls asserted
    step(0,0,0,1, 1,1,1, 4'd11, 32'hCCCC, 32'hDDDD, 4'b1100);
    // full-width extremes
    step(0,0,1,1, 1,1,1, 4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF);
    // mid-cycle reset from a valid, status=F state
    mid_reset();
    step(0,0,1,0, 1,0,0, 4'd12, 32'h1234_5678, 32'h0, 4'h0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) == 0) mid_reset();
      else rand_step(20, 15);
    end

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_leftover: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
